// File: rtl/wgt_mem_writer_if.sv
// Weight-load bus: host-side stream in, single-word SRAM write strobes out.
// Rev 1.0
`default_nettype none

interface wgt_mem_writer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic                  start;
  logic [DATA_WIDTH-1:0] wgt_in;
  logic                  wgt_valid;
  logic                  wgt_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start, wgt_in, wgt_valid,
    input  wgt_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, wgt_in, wgt_valid,
    output wgt_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/wgt_mem_writer.sv
// wgt_mem_writer: writes a filter-major weight stream into the filter-interleaved SRAM layout.
// Rev 1.0
`default_nettype none

module wgt_mem_writer #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int NO_CHANNEL    = 3,
  parameter int NO_FILTER     = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 9
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  wgt_mem_writer_if.slave     bus
);

  localparam int KKC       = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
  localparam int REM       = NO_FILTER % SYSTOLIC_SIZE;
  localparam int NUM_TILES = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int LAST_SZ   = (REM == 0) ? SYSTOLIC_SIZE : REM;

  localparam logic [ADDR_WIDTH-1:0] KKC_LAST    = ADDR_WIDTH'(KKC - 1);
  localparam logic [ADDR_WIDTH-1:0] TILE_LAST   = ADDR_WIDTH'(NUM_TILES - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_SZ     = ADDR_WIDTH'(SYSTOLIC_SIZE);
  localparam logic [ADDR_WIDTH-1:0] PART_SZ     = ADDR_WIDTH'(LAST_SZ);
  localparam logic [ADDR_WIDTH-1:0] TILE_STRIDE = ADDR_WIDTH'(KKC * SYSTOLIC_SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] k_cnt;
  logic [ADDR_WIDTH-1:0] lane;
  logic [ADDR_WIDTH-1:0] tile;
  logic [ADDR_WIDTH-1:0] tile_base;
  logic [ADDR_WIDTH-1:0] k_off;

  logic                  ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  last_tile;
  logic [ADDR_WIDTH-1:0] sz;
  logic                  lane_last;
  logic                  k_last;
  logic                  accept;
  logic                  final_beat;

  // The trailing tile holds only the leftover filters, so its lane stride shrinks.
  always_comb begin
    last_tile  = (tile == TILE_LAST);
    sz         = last_tile ? PART_SZ : FULL_SZ;
    lane_last  = (lane == sz - 1'b1);
    k_last     = (k_cnt == KKC_LAST);
    accept     = (state == S_WRITE) && ready_q && bus.wgt_valid;
    final_beat = last_tile && lane_last && k_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_cnt     <= '0;
      lane      <= '0;
      tile      <= '0;
      tile_base <= '0;
      k_off     <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_WRITE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            k_cnt     <= '0;
            lane      <= '0;
            tile      <= '0;
            tile_base <= '0;
            k_off     <= '0;
          end
        end

        S_WRITE: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= tile_base + k_off + lane;
            wr_data_q <= bus.wgt_in;
            if (k_last) begin
              k_cnt <= '0;
              k_off <= '0;
              if (lane_last) begin
                lane      <= '0;
                tile      <= tile + 1'b1;
                tile_base <= tile_base + TILE_STRIDE;
              end else begin
                lane <= lane + 1'b1;
              end
            end else begin
              k_cnt <= k_cnt + 1'b1;
              k_off <= k_off + sz;
            end
            if (final_beat) begin
              state   <= S_DONE;
              ready_q <= 1'b0;
            end
          end
        end

        S_DONE: begin
          // First DONE cycle lets the final write retire; the second carries the pulse.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wgt_ready = ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire
